// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11x128 register file.
// Optional macro AES_KEY_ZEROIZE_EN adds a synchronous i_Zeroize clear of all key material.
module aes_key_sched_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned RD_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_Start,
    input  logic [127:0] i_Key,
    output logic         o_Busy,
    output logic         o_Done,
    output logic         o_Key_Valid,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic         i_Zeroize,
`endif
    input  logic [3:0]   i_Rd_Round,
    output logic [127:0] o_Rd_Key
);

    if (NR != 10) begin : g_nr_check
        $error("aes_key_sched_ctrl supports only NR = 10 (AES-128)");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] w_q, w_d;
    logic [127:0] slot_q [0:NR];
    logic [127:0] slot_d [0:NR];
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         valid_q, valid_d;
    logic         zeroize;
    logic [31:0]  rot_word, t_word, w4, w5, w6, w7;
    logic [127:0] next_key, rd_word;

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize = i_Zeroize;
`else
    assign zeroize = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)), gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        rot_word = {w_q[23:0], w_q[31:24]};
        t_word   = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])} ^ {rcon_q, 24'h0};
        w4       = w_q[127:96] ^ t_word;
        w5       = w_q[95:64]  ^ w4;
        w6       = w_q[63:32]  ^ w5;
        w7       = w_q[31:0]   ^ w6;
        next_key = {w4, w5, w6, w7};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        w_d     = w_q;
        slot_d  = slot_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        if (zeroize) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rcon_d  = 8'h01;
            w_d     = '0;
            for (int unsigned i = 0; i <= NR; i++) slot_d[i] = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_Start) begin
                        state_d   = ST_EXPAND;
                        slot_d[0] = i_Key;
                        w_d       = i_Key;
                        cnt_d     = 4'd1;
                        rcon_d    = 8'h01;
                        busy_d    = 1'b1;
                        valid_d   = 1'b0;
                    end
                end
                ST_EXPAND: begin
                    for (int unsigned i = 1; i <= NR; i++) begin
                        if (cnt_q == 4'(i)) slot_d[i] = next_key;
                    end
                    w_d    = next_key;
                    cnt_d  = cnt_q + 4'd1;
                    rcon_d = xtime(rcon_q);
                    if (cnt_q == 4'(NR)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rcon_q  <= 8'h01;
            w_q     <= '0;
            for (int unsigned i = 0; i <= NR; i++) slot_q[i] <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            w_q     <= w_d;
            slot_q  <= slot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Indices past NR read as zero rather than aliasing into storage.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (i_Rd_Round == 4'(i)) rd_word = slot_q[i];
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [127:0] rd_key_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_key_q <= '0;
            else        rd_key_q <= rd_word;
        end
        assign o_Rd_Key = rd_key_q;
    end else begin : g_rd_comb
        assign o_Rd_Key = rd_word;
    end

    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Key_Valid = valid_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy, done, valid;
    logic [3:0]   rd;
    logic [127:0] rd_key;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } rd_vec_t;

    rd_vec_t      vecs [13];
    logic [127:0] fips [0:10];
    localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    aes_key_sched_ctrl #(.NR(10), .RD_REG(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_Start     (start),
        .i_Key       (key),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Key_Valid (valid),
`ifdef AES_KEY_ZEROIZE_EN
        .i_Zeroize   (zeroize),
`endif
        .i_Rd_Round  (rd),
        .o_Rd_Key    (rd_key)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_expand(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
        for (int k2 = 1; k2 <= 10; k2++) tick();
        chk1("expand_done", done, 1'b1);
        chk1("expand_valid", valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) begin
            vecs[i].idx = 4'(i);
            vecs[i].exp = fips[i];
        end
        vecs[11].idx = 4'd11; vecs[11].exp = '0;
        vecs[12].idx = 4'd15; vecs[12].exp = '0;

        rst_n = 1'b0;
        start = 1'b0;
        key   = '0;
        rd    = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        #12;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_valid", valid, 1'b0);
        chk("reset_rd_key", rd_key, '0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            rd = 4'(i);
            tick();
            chk("idle_read", rd_key, '0);
        end
        chk1("idle_busy", busy, 1'b0);

        // FIPS-197 expansion with cycle-exact handshake checks
        rd    = 4'd10;
        start = 1'b1;
        key   = fips[0];
        tick();
        start = 1'b0;
        chk1("accept_busy", busy, 1'b1);
        chk1("accept_valid", valid, 1'b0);
        chk1("accept_done", done, 1'b0);
        busy_cnt = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (busy) busy_cnt++;
            chk1("done_timing", done, (k == 10));
        end
        chk("busy_cycles", 128'(busy_cnt), 128'd10);
        chk1("done_valid", valid, 1'b1);
        chk("same_edge_old_value", rd_key, '0);
        tick();
        chk1("done_pulse_end", done, 1'b0);
        chk1("valid_hold", valid, 1'b1);
        chk("round10_first_read", rd_key, fips[10]);
        for (int i = 0; i < 13; i++) begin
            rd = vecs[i].idx;
            tick();
            chk($sformatf("rd_round_%0d", vecs[i].idx), rd_key, vecs[i].exp);
        end
        rd = 4'd1;
        #1;
        chk("rd_latency_hold", rd_key, '0);
        tick();
        chk("rd_latency_update", rd_key, fips[1]);

        // i_Start held with a changing key: first (zero) key must win
        start = 1'b1;
        key   = '0;
        tick();
        chk1("restart_valid_drop", valid, 1'b0);
        chk1("restart_busy", busy, 1'b1);
        key = fips[0];
        rd  = 4'd1;
        tick();
        tick();
        chk("held_zero_r1", rd_key, ZERO_R1);
        rd = 4'd2;
        tick();
        chk("held_zero_r2", rd_key, ZERO_R2);
        for (int k = 4; k <= 10; k++) tick();
        chk1("held_done", done, 1'b1);
        chk1("held_valid", valid, 1'b1);
        rd = 4'd0;
        tick();
        chk("held_slot0_zero", rd_key, '0);
        chk1("second_run_valid", valid, 1'b0);
        chk1("second_run_busy", busy, 1'b1);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk1("second_run_done", done, 1'b1);
        rd = 4'd1;
        tick();
        chk("second_run_r1", rd_key, fips[1]);
        rd = 4'd0;
        tick();
        chk("second_run_r0", rd_key, fips[0]);

        // Reset pulsed after EXPAND edge 5
        rd    = 4'd3;
        start = 1'b1;
        key   = fips[0];
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk("mid_read_r3", rd_key, fips[3]);
        chk1("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_valid", valid, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk("abort_rd_key", rd_key, '0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("abort_slot3_cleared", rd_key, '0);
        chk1("abort_idle", busy, 1'b0);
        rd = 4'd0;
        tick();
        chk("abort_slot0_cleared", rd_key, '0);
        run_expand(fips[0]);
        rd = 4'd10;
        tick();
        chk("rerun_round10", rd_key, fips[10]);

`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk1("zeroize_valid", valid, 1'b0);
        chk1("zeroize_busy", busy, 1'b0);
        chk1("zeroize_done", done, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            rd = 4'(i);
            tick();
            chk("zeroize_slot", rd_key, '0);
        end
        start   = 1'b1;
        zeroize = 1'b1;
        key     = fips[0];
        tick();
        start   = 1'b0;
        zeroize = 1'b0;
        chk1("zeroize_vs_start_busy", busy, 1'b0);
        chk1("zeroize_vs_start_valid", valid, 1'b0);
        tick();
        chk1("zeroize_stays_idle", busy, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
